// File: rtl/chip8_fetch_ctrl.sv
// CHIP-8 instruction sequencer: owns PC and call stack, fetches 2-byte opcodes,
// executes control flow locally and hands other opcodes to the datapath.
module chip8_fetch_ctrl #(
    parameter logic [11:0] START_ADDR  = 12'h200,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         run,
    output logic [11:0]                  mem_addr,
    output logic                         mem_rd,
    input  logic [7:0]                   mem_rdata,
    output logic [15:0]                  opcode,
    input  logic [3:0]                   op_main,
    input  logic [11:0]                  nnn,
    output logic                         exec_start,
    input  logic                         exec_done,
    input  logic                         skip,
    input  logic [7:0]                   v0,
    output logic [11:0]                  pc,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         fault
);

    localparam int unsigned   IdxW   = $clog2(STACK_DEPTH);
    localparam logic [IdxW:0] SpFull = STACK_DEPTH[IdxW:0];
    localparam logic [IdxW:0] SpOne  = (IdxW + 1)'(1);

    typedef enum logic [2:0] {
        StFetchHi,
        StFetchLo,
        StDecode,
        StCtrl,
        StExec,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [11:0]     pc_q, pc_d;
    logic [IdxW:0]   sp_q, sp_d;
    logic [15:0]     opcode_q, opcode_d;
    logic            fault_q, fault_d;
    logic [11:0]     mem_addr_q;
    logic [11:0]     stack_q [STACK_DEPTH];
    logic            push;
    logic [IdxW-1:0] push_idx, pop_idx;

    assign push_idx = sp_q[IdxW-1:0];
    assign pop_idx  = IdxW'(sp_q - SpOne);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        opcode_d   = opcode_q;
        fault_d    = fault_q;
        mem_rd     = 1'b0;
        mem_addr   = mem_addr_q;
        exec_start = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            StFetchHi: begin
                if (run) begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_q;
                    state_d  = StFetchLo;
                end
            end
            StFetchLo: begin
                opcode_d[15:8] = mem_rdata;
                mem_rd         = 1'b1;
                mem_addr       = pc_q + 12'd1;
                state_d        = StDecode;
            end
            StDecode: begin
                opcode_d[7:0] = mem_rdata;
                state_d       = StCtrl;
            end
            StCtrl: begin
                state_d = StFetchHi;
                if (opcode_q == 16'h00EE) begin
                    if (sp_q == '0) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        pc_d = stack_q[pop_idx];
                        sp_d = sp_q - SpOne;
                    end
                end else if (op_main == 4'h1) begin
                    pc_d = nnn;
                end else if (op_main == 4'h2) begin
                    if (sp_q == SpFull) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SpOne;
                        pc_d = nnn;
                    end
                end else if (op_main == 4'hB) begin
                    pc_d = nnn + {4'h0, v0};
                end else begin
                    exec_start = 1'b1;
                    state_d    = StExec;
                end
            end
            StExec: begin
                if (exec_done) begin
                    pc_d    = pc_q + (skip ? 12'd4 : 12'd2);
                    state_d = StFetchHi;
                end
            end
            StHalt: ;
            default: state_d = StHalt;
        endcase
        // Keep strobes quiet while reset is being applied.
        if (!reset_n) begin
            mem_rd     = 1'b0;
            mem_addr   = mem_addr_q;
            exec_start = 1'b0;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StFetchHi;
            pc_q       <= START_ADDR;
            sp_q       <= '0;
            opcode_q   <= 16'h0000;
            fault_q    <= 1'b0;
            mem_addr_q <= START_ADDR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            opcode_q   <= opcode_d;
            fault_q    <= fault_d;
            mem_addr_q <= mem_addr;
        end
    end

    // Stack contents survive reset; only sp is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_q + 12'd2;
        end
    end

    assign pc     = pc_q;
    assign sp     = sp_q;
    assign opcode = opcode_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_chip8_fetch_ctrl.sv
// Directed bench for chip8_fetch_ctrl with a byte-wide program memory, a
// decoder stub and a datapath model with programmable completion delay.
module tb_chip8_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] opcode;
    logic [3:0]  op_main;
    logic [11:0] nnn;
    logic        exec_start;
    logic        exec_done;
    logic        skip;
    logic [7:0]  v0;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        fault;

    logic [7:0]  mem [4096];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_exec = 0;
    int          n_rd = 0;
    int          dp_delay = 0;
    int          dp_cnt = 0;
    logic        dp_busy = 1'b0;
    int          e0, r0;

    always #5 clk = ~clk;

    chip8_fetch_ctrl #(
        .START_ADDR (12'h200),
        .STACK_DEPTH(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .opcode    (opcode),
        .op_main   (op_main),
        .nnn       (nnn),
        .exec_start(exec_start),
        .exec_done (exec_done),
        .skip      (skip),
        .v0        (v0),
        .pc        (pc),
        .sp        (sp),
        .fault     (fault)
    );

    assign op_main   = opcode[15:12];
    assign nnn       = opcode[11:0];
    assign exec_done = dp_busy && (dp_cnt == 0);

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_rd) n_rd <= n_rd + 1;
        if (exec_start) n_exec <= n_exec + 1;
        if (exec_start) begin
            dp_busy <= 1'b1;
            dp_cnt  <= dp_delay;
        end else if (dp_busy && dp_cnt != 0) begin
            dp_cnt <= dp_cnt - 1;
        end else if (dp_busy) begin
            dp_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] hi, input logic [7:0] lo);
        mem[a]         = hi;
        mem[a + 12'd1] = lo;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        step(1);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        skip    = 1'b0;
        v0      = 8'h00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Fetch and skip
        load(12'h200, 8'h60, 8'h12);
        load(12'h202, 8'h30, 8'h12);
        step(1);
        check("rst_pc", pc, 12'h200);
        check("rst_sp", sp, 5'd0);
        check("rst_opcode", opcode, 16'h0000);
        check("rst_fault", fault, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 12'h200);
        check("rst_exec_start", exec_start, 1'b0);
        reset_n = 1'b1;
        run     = 1'b1;
        e0      = n_exec;
        #1;
        check("fhi_mem_rd", mem_rd, 1'b1);
        check("fhi_mem_addr", mem_addr, 12'h200);
        step(1);
        check("flo_mem_rd", mem_rd, 1'b1);
        check("flo_mem_addr", mem_addr, 12'h201);
        step(1);
        check("dec_mem_rd", mem_rd, 1'b0);
        step(1);
        check("ctrl_opcode", opcode, 16'h6012);
        check("ctrl_exec_start", exec_start, 1'b1);
        step(1);
        check("exec_no_restart", exec_start, 1'b0);
        check("exec_pc_hold", pc, 12'h200);
        step(1);
        check("dp_pc", pc, 12'h202);
        check("dp_one_start", n_exec - e0, 1);
        skip = 1'b1;
        step(4);
        check("skip_opcode", opcode, 16'h3012);
        step(1);
        check("skip_pc", pc, 12'h206);
        run  = 1'b0;
        skip = 1'b0;

        // Jump and run gating
        load(12'h200, 8'h1A, 8'hBC);
        do_reset();
        run = 1'b1;
        e0  = n_exec;
        step(3);
        check("jp_ctrl_pc", pc, 12'h200);
        step(1);
        check("jp_pc", pc, 12'hABC);
        check("jp_no_exec", n_exec - e0, 0);
        run = 1'b0;
        r0  = n_rd;
        step(6);
        check("idle_mem_rd", mem_rd, 1'b0);
        check("idle_rd_count", n_rd - r0, 0);
        check("idle_pc", pc, 12'hABC);
        run = 1'b1;
        #1;
        check("resume_mem_rd", mem_rd, 1'b1);
        check("resume_addr", mem_addr, 12'hABC);
        step(1);
        run = 1'b0;

        // CALL / RET
        load(12'h200, 8'h23, 8'h00);
        load(12'h300, 8'h00, 8'hEE);
        do_reset();
        run = 1'b1;
        e0  = n_exec;
        step(4);
        check("call_sp", sp, 5'd1);
        check("call_pc", pc, 12'h300);
        step(4);
        check("ret_sp", sp, 5'd0);
        check("ret_pc", pc, 12'h202);
        check("callret_no_exec", n_exec - e0, 0);
        run = 1'b0;

        // Stack overflow: chain of 17 CALLs
        load(12'h200, 8'h24, 8'h00);
        for (int i = 0; i < 17; i++) begin
            logic [11:0] a;
            a = 12'h400 + 12'(2 * i);
            load(a, {4'h2, 4'(a >> 8)}, 8'(a + 12'd2));
        end
        do_reset();
        run = 1'b1;
        step(64);
        check("ovf_sp16", sp, 5'd16);
        check("ovf_pc16", pc, 12'h41E);
        step(3);
        check("ovf_fault_pre", fault, 1'b0);
        step(1);
        check("ovf_fault", fault, 1'b1);
        r0 = n_rd;
        e0 = n_exec;
        step(5);
        check("halt_mem_rd", mem_rd, 1'b0);
        check("halt_rd_count", n_rd - r0, 0);
        check("halt_no_exec", n_exec - e0, 0);
        check("halt_pc", pc, 12'h41E);
        check("halt_sp", sp, 5'd16);
        check("halt_fault_sticky", fault, 1'b1);

        // Stack underflow
        load(12'h200, 8'h00, 8'hEE);
        do_reset();
        check("unf_fault_clear", fault, 1'b0);
        run = 1'b1;
        step(4);
        check("unf_fault", fault, 1'b1);
        check("unf_pc", pc, 12'h200);
        check("unf_sp", sp, 5'd0);

        // BNNN wrap, then a stalled datapath instruction
        load(12'h200, 8'hBF, 8'hF0);
        load(12'h0EF, 8'h8A, 8'hB5);
        do_reset();
        v0       = 8'hFF;
        dp_delay = 10;
        run      = 1'b1;
        step(4);
        check("bnnn_pc", pc, 12'h0EF);
        e0 = n_exec;
        step(1);
        run = 1'b0;
        step(2);
        check("stall_opcode", opcode, 16'h8AB5);
        check("stall_exec_start", exec_start, 1'b1);
        step(5);
        check("stall_pc_hold", pc, 12'h0EF);
        check("stall_one_start", n_exec - e0, 1);
        step(6);
        check("stall_pc_last", pc, 12'h0EF);
        step(1);
        check("stall_pc_done", pc, 12'h0F1);
        check("stall_one_start_end", n_exec - e0, 1);

        // Reset during EXEC, then a late exec_done
        load(12'h200, 8'h23, 8'h00);
        load(12'h300, 8'h60, 8'h12);
        do_reset();
        dp_delay = 5;
        run      = 1'b1;
        step(8);
        check("pre_rst_sp", sp, 5'd1);
        run     = 1'b0;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("rexec_pc", pc, 12'h200);
        check("rexec_sp", sp, 5'd0);
        check("rexec_fault", fault, 1'b0);
        check("rexec_exec_start", exec_start, 1'b0);
        check("rexec_mem_rd", mem_rd, 1'b0);
        step(8);
        check("late_done_pc", pc, 12'h200);
        check("late_done_sp", sp, 5'd0);

        // Reset during FETCH_LO
        dp_delay = 0;
        run      = 1'b1;
        step(5);
        check("pre_flo_opcode", opcode, 16'h2300);
        run     = 1'b0;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("rflo_pc", pc, 12'h200);
        check("rflo_sp", sp, 5'd0);
        check("rflo_opcode", opcode, 16'h0000);
        check("rflo_mem_rd", mem_rd, 1'b0);
        run = 1'b1;
        #1;
        check("rflo_refetch", mem_addr, 12'h200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
